// File: rtl/fir_filter_pkg.sv
// Shared types and the rounding/saturation stage for the multi-channel FIR.
// Widths here match the default parameters of fir_filter_mc.
package fir_filter_pkg;

  localparam int FirOrder      = 15;
  localparam int FirChannels   = 4;
  localparam int FirDataWidth  = 16;
  localparam int FirCoeffWidth = 16;
  localparam int FirCoeffFrac  = 15;
  localparam int FirAddrWidth  = $clog2(FirOrder + 1);
  localparam int FirAccWidth   = FirDataWidth + FirCoeffWidth + FirAddrWidth;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

  localparam logic signed [FirAccWidth-1:0] RoundHalf = FirAccWidth'(2 ** (FirCoeffFrac - 1));
  localparam logic signed [FirAccWidth-1:0] SatMax    = FirAccWidth'(2 ** (FirDataWidth - 1) - 1);
  localparam logic signed [FirAccWidth-1:0] SatMin    = ~SatMax;

  // Round half toward +inf, drop the coefficient fraction, clamp to the sample range.
  function automatic logic signed [FirDataWidth-1:0] sat_round(
    input logic signed [FirAccWidth-1:0] acc
  );
    logic signed [FirAccWidth-1:0] shifted;
    shifted = (acc + RoundHalf) >>> FirCoeffFrac;
    if (shifted > SatMax) return SatMax[FirDataWidth-1:0];
    if (shifted < SatMin) return SatMin[FirDataWidth-1:0];
    return shifted[FirDataWidth-1:0];
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply-accumulate with clear/enable; on the last tap the rounded,
// saturated result is captured in the same edge as the final accumulation.
module fir_mac
  import fir_filter_pkg::*;
#(
  parameter int DataWidth  = FirDataWidth,
  parameter int CoeffWidth = FirCoeffWidth,
  parameter int AccWidth   = FirAccWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic                         last_i,
  input  logic signed [DataWidth-1:0]  sample_i,
  input  logic signed [CoeffWidth-1:0] coeff_i,
  output logic signed [DataWidth-1:0]  res_o
);

  logic signed [DataWidth+CoeffWidth-1:0] prod;
  logic signed [AccWidth-1:0]             acc_q, acc_d;
  logic signed [DataWidth-1:0]            res_q, res_d;

  assign prod = sample_i * coeff_i;

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AccWidth'(prod);
    end
    if (en_i && last_i) res_d = sat_round(acc_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed FIR: one sample in flight, output request Order+2 cycles after the
// input grant; the result is held until data_out_gnt_i, and no input is taken meanwhile.
module fir_filter_mc
  import fir_filter_pkg::*;
#(
  parameter int    Order       = FirOrder,
  parameter int    NumChannels = FirChannels,
  parameter int    DataWidth   = FirDataWidth,
  parameter int    CoeffWidth  = FirCoeffWidth,
  parameter int    CoeffFrac   = FirCoeffFrac,
  localparam int   AddrWidth   = $clog2(Order + 1),
  localparam int   ChWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int   AccWidth    = DataWidth + CoeffWidth + AddrWidth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         data_in_req_i,
  output logic                         data_in_gnt_o,
  input  logic signed [DataWidth-1:0]  data_in_i,
  input  logic [ChWidth-1:0]           data_in_ch_i,
  output logic                         data_out_req_o,
  input  logic                         data_out_gnt_i,
  output logic signed [DataWidth-1:0]  data_out_o,
  output logic [ChWidth-1:0]           data_out_ch_o,
  input  logic                         coeff_we_i,
  output logic                         coeff_gnt_o,
  input  logic [AddrWidth-1:0]         coeff_addr_i,
  input  logic signed [CoeffWidth-1:0] coeff_i,
  input  logic                         clear_i
);

  localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(Order);
  localparam logic [AddrWidth-1:0] NumTaps = AddrWidth'(Order + 1);

  state_e                      state_q, state_d;
  logic [ChWidth-1:0]          ch_q;
  logic [AddrWidth-1:0]        tap_q, tap_d, rd_idx, ptr_cur;
  logic signed [DataWidth-1:0] hist_q [NumChannels][Order+1];
  logic [AddrWidth-1:0]        wr_ptr_q [NumChannels];
  logic signed [CoeffWidth-1:0] coeff_q [Order+1];
  logic                        ch_ok, in_fire, mac_en, mac_last;

  if ((2 ** ChWidth) > NumChannels) begin : g_ch_chk
    assign ch_ok = (32'(data_in_ch_i) < NumChannels);
  end else begin : g_ch_all
    assign ch_ok = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    data_in_gnt_o  = 1'b0;
    coeff_gnt_o    = 1'b0;
    data_out_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst_i) begin
          data_in_gnt_o = data_in_req_i && !clear_i;
          coeff_gnt_o   = coeff_we_i && !data_in_req_i && !clear_i;
        end
        if (data_in_gnt_o && ch_ok) state_d = MAC;
      end
      MAC:     if (tap_q == LastTap) state_d = OUT;
      OUT: begin
        data_out_req_o = 1'b1;
        if (data_out_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_fire  = data_in_gnt_o && ch_ok;
  assign mac_en   = (state_q == MAC);
  assign mac_last = mac_en && (tap_q == LastTap);
  assign tap_d    = in_fire ? '0 : (mac_en ? tap_q + AddrWidth'(1) : tap_q);

  // Newest sample sits at the latched write pointer; tap k looks k samples back.
  assign ptr_cur = wr_ptr_q[ch_q];
  assign rd_idx  = (ptr_cur >= tap_q) ? ptr_cur - tap_q : ptr_cur + NumTaps - tap_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tap_q   <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        wr_ptr_q[c] <= '0;
        for (int k = 0; k <= Order; k++) hist_q[c][k] <= '0;
      end
      for (int k = 0; k <= Order; k++) coeff_q[k] <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      if (in_fire) begin
        ch_q <= data_in_ch_i;
        hist_q[data_in_ch_i][wr_ptr_q[data_in_ch_i]] <= data_in_i;
      end
      if (mac_last) wr_ptr_q[ch_q] <= (ptr_cur == LastTap) ? '0 : ptr_cur + AddrWidth'(1);
      if (state_q == IDLE && clear_i) begin
        for (int c = 0; c < NumChannels; c++) begin
          wr_ptr_q[c] <= '0;
          for (int k = 0; k <= Order; k++) hist_q[c][k] <= '0;
        end
      end
      if (coeff_gnt_o) coeff_q[coeff_addr_i] <= coeff_i;
    end
  end

  fir_mac #(
    .DataWidth (DataWidth),
    .CoeffWidth(CoeffWidth),
    .AccWidth  (AccWidth)
  ) u_mac (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (in_fire),
    .en_i    (mac_en),
    .last_i  (mac_last),
    .sample_i(hist_q[ch_q][rd_idx]),
    .coeff_i (coeff_q[tap_q]),
    .res_o   (data_out_o)
  );

  assign data_out_ch_o = ch_q;

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc with a behavioural reference model and scoreboard.
module tb_fir_filter_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_in_req, data_in_gnt_o;
  logic [15:0] data_in;
  logic [1:0]  data_in_ch;
  logic        data_out_req_o, data_out_gnt;
  logic [15:0] data_out_o;
  logic [1:0]  data_out_ch_o;
  logic        coeff_we, coeff_gnt_o, clear;
  logic [3:0]  coeff_addr;
  logic [15:0] coeff_din;

  fir_filter_mc dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .data_in_req_i (data_in_req),
    .data_in_gnt_o (data_in_gnt_o),
    .data_in_i     (data_in),
    .data_in_ch_i  (data_in_ch),
    .data_out_req_o(data_out_req_o),
    .data_out_gnt_i(data_out_gnt),
    .data_out_o    (data_out_o),
    .data_out_ch_o (data_out_ch_o),
    .coeff_we_i    (coeff_we),
    .coeff_gnt_o   (coeff_gnt_o),
    .coeff_addr_i  (coeff_addr),
    .coeff_i       (coeff_din),
    .clear_i       (clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  int m_hist[4][16];
  int m_ptr[4];
  int m_coef[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sample(input int ch, input int x);
    longint acc = 0;
    longint r;
    int idx;
    m_hist[ch][m_ptr[ch]] = x;
    for (int k = 0; k < 16; k++) begin
      idx = (m_ptr[ch] - k + 16) % 16;
      acc += longint'(m_hist[ch][idx]) * longint'(m_coef[k]);
    end
    m_ptr[ch] = (m_ptr[ch] + 1) % 16;
    r = (acc + 64'sd16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic model_reset(input bit with_coefs);
    for (int c = 0; c < 4; c++) begin
      m_ptr[c] = 0;
      for (int k = 0; k < 16; k++) m_hist[c][k] = 0;
    end
    if (with_coefs) for (int k = 0; k < 16; k++) m_coef[k] = 0;
  endtask

  task automatic send(input int ch, input int x, output int t_gnt);
    int n = 0;
    exp_t e;
    data_in_req = 1'b1;
    data_in_ch  = 2'(ch);
    data_in     = 16'(x);
    #1;
    while (!data_in_gnt_o && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_gnt", 32'(data_in_gnt_o), 32'd1);
    t_gnt = cyc;
    if (data_in_gnt_o) begin
      e.ch  = 2'(ch);
      e.val = model_sample(ch, x);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    data_in_req = 1'b0;
  endtask

  task automatic wait_out(input int t_gnt);
    int n = 0;
    while (!data_out_req_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_req", 32'(data_out_req_o), 32'd1);
    chk("latency", cyc, t_gnt + 17);
  endtask

  task automatic consume();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard: observed output %0h, expected none pending", data_out_o);
    end else begin
      e = sb.pop_front();
      chk("data", 32'(data_out_o), 32'(e.val));
      chk("ch", 32'(data_out_ch_o), 32'(e.ch));
    end
    data_out_gnt = 1'b1;
    @(posedge clk); #1;
    data_out_gnt = 1'b0;
    chk("req_drop", 32'(data_out_req_o), 32'd0);
  endtask

  task automatic sample(input int ch, input int x);
    int t;
    send(ch, x, t);
    wait_out(t);
    consume();
  endtask

  task automatic sample_lit(input int ch, input int x, input logic [15:0] lit);
    int t;
    send(ch, x, t);
    wait_out(t);
    chk("literal", 32'(data_out_o), 32'(lit));
    consume();
  endtask

  task automatic wcoef(input int a, input int v);
    int n = 0;
    coeff_we   = 1'b1;
    coeff_addr = 4'(a);
    coeff_din  = 16'(v);
    #1;
    while (!coeff_gnt_o && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("coeff_gnt", 32'(coeff_gnt_o), 32'd1);
    if (coeff_gnt_o) m_coef[a] = v;
    @(posedge clk); #1;
    coeff_we = 1'b0;
  endtask

  task automatic do_clear(input bit with_req);
    clear       = 1'b1;
    data_in_req = with_req;
    data_in_ch  = 2'd0;
    data_in     = 16'd0;
    #1;
    if (with_req) chk("clear_beats_in", 32'(data_in_gnt_o), 32'd0);
    model_reset(1'b0);
    @(posedge clk); #1;
    clear       = 1'b0;
    data_in_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic [15:0] snap;
    rst = 1'b1; data_in_req = 1'b1; data_in = 16'd0; data_in_ch = 2'd0;
    data_out_gnt = 1'b0; coeff_we = 1'b1; coeff_addr = 4'd0; coeff_din = 16'h1234; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_gnt", 32'(data_in_gnt_o), 32'd0);
    chk("rst_coeff_gnt", 32'(coeff_gnt_o), 32'd0);
    chk("rst_out_req", 32'(data_out_req_o), 32'd0);
    chk("rst_out", 32'(data_out_o), 32'd0);
    chk("rst_out_ch", 32'(data_out_ch_o), 32'd0);
    data_in_req = 1'b0; coeff_we = 1'b0; rst = 1'b0;
    model_reset(1'b1);
    @(posedge clk); #1;

    // impulse response on ch0
    wcoef(0, 16384);
    wcoef(1, 8192);
    sample_lit(0, 1000, 16'd500);
    sample_lit(0, 0, 16'd250);
    sample_lit(0, 0, 16'd0);

    // rounding with a single half-gain tap
    wcoef(1, 0);
    do_clear(1'b0);
    sample_lit(0, 3, 16'd2);
    sample_lit(0, -3, 16'hFFFF);
    sample_lit(0, 1, 16'd1);

    // channel isolation
    wcoef(1, 8192);
    do_clear(1'b0);
    sample_lit(1, 1000, 16'd500);
    sample_lit(3, 0, 16'd0);
    sample_lit(1, 0, 16'd250);
    sample_lit(3, 0, 16'd0);
    sample_lit(1, 0, 16'd0);
    sample_lit(3, 0, 16'd0);

    // saturation on ch2
    for (int k = 0; k < 16; k++) wcoef(k, 32767);
    for (int i = 0; i < 15; i++) sample(2, 32767);
    sample_lit(2, 32767, 16'h7FFF);
    for (int i = 0; i < 15; i++) sample(2, -32768);
    sample_lit(2, -32768, 16'h8000);

    // output backpressure
    for (int k = 0; k < 16; k++) wcoef(k, (k == 0) ? 16384 : 0);
    do_clear(1'b0);
    send(0, 800, t);
    wait_out(t);
    snap = data_out_o;
    data_in_req = 1'b1; data_in_ch = 2'd0; data_in = 16'd7;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_stable", 32'(data_out_o), 32'(snap));
      chk("bp_req", 32'(data_out_req_o), 32'd1);
      chk("bp_in_gnt", 32'(data_in_gnt_o), 32'd0);
    end
    consume();
    send(0, 7, t);
    wait_out(t);
    consume();

    // sample beats a coefficient write; the write lands afterwards
    coeff_we = 1'b1; coeff_addr = 4'd2; coeff_din = 16'd4096;
    data_in_req = 1'b1; data_in_ch = 2'd0; data_in = 16'd200;
    #1;
    chk("prio_in_gnt", 32'(data_in_gnt_o), 32'd1);
    chk("prio_coeff_gnt", 32'(coeff_gnt_o), 32'd0);
    send(0, 200, t);
    chk("mac_coeff_gnt", 32'(coeff_gnt_o), 32'd0);
    wait_out(t);
    consume();
    wcoef(2, 4096);
    sample(0, 0);

    // reset in the fifth MAC cycle
    send(1, 1234, t);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(data_out_req_o), 32'd0);
    chk("mid_rst_out", 32'(data_out_o), 32'd0);
    chk("mid_rst_ch", 32'(data_out_ch_o), 32'd0);
    sb.delete();
    model_reset(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req", 32'(data_out_req_o), 32'd0);
    wcoef(0, 16384);
    wcoef(1, 8192);
    sample_lit(0, 1000, 16'd500);
    sample_lit(0, 0, 16'd250);

    // clear hides earlier history and wins over a concurrent sample
    sample(0, 1000);
    do_clear(1'b1);
    sample_lit(0, 0, 16'd0);
    sample_lit(0, 0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_filter_mc.md
Name: fir_filter_mc

Overview:
- Multi-channel, time-multiplexed FIR filter with a single shared multiply-accumulate unit.
- Per-channel sample history; one programmable coefficient set shared by all channels.
- Sits in the streaming datapath between sample producers and consumers, using req/gnt handshakes on both sides.
- Coefficients are loaded at run time through a simple write port.

Parameters:
- Order, 15, filter order; Order+1 taps.
- AddrWidth, $clog2(Order+1), tap index width; derived, do not override.
- NumChannels, 4, number of independent channels.
- ChWidth, $clog2(NumChannels) (min 1), channel index width; derived.
- DataWidth, 16, signed sample width (input and output).
- CoeffWidth, 16, signed coefficient width.
- CoeffFrac, 15, fractional bits of the coefficients; product shift amount.
- AccWidth, DataWidth+CoeffWidth+AddrWidth, accumulator width; derived.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- data_in_req_i  in  1  input sample valid
- data_in_gnt_o  out  1  input sample accepted
- data_in_i  in  DataWidth  signed input sample
- data_in_ch_i  in  ChWidth  channel of input sample
- data_out_req_o  out  1  output sample valid
- data_out_gnt_i  in  1  output sample consumed
- data_out_o  out  DataWidth  signed filtered sample
- data_out_ch_o  out  ChWidth  channel of output sample
- coeff_we_i  in  1  coefficient write request
- coeff_gnt_o  out  1  coefficient write accepted
- coeff_addr_i  in  AddrWidth  tap index
- coeff_i  in  CoeffWidth  signed coefficient value
- clear_i  in  1  synchronous clear of all channel histories

Behaviour:
- Reset (async, active-high): FSM to IDLE; all histories, write pointers, coefficients and accumulator zeroed.
- Output values while reset is asserted: data_in_gnt_o=0, coeff_gnt_o=0, data_out_req_o=0, data_out_o=0, data_out_ch_o=0.
- Reset mid-operation aborts any computation or pending output; no partial output is ever presented.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - data_in_gnt_o = data_in_req_i && !clear_i.
  - coeff_gnt_o = coeff_we_i && !data_in_req_i && !clear_i (samples have priority over coefficient writes).
- IDLE, on input grant:
  - Write the sample into history[ch] at wr_ptr[ch].
  - Latch ch; clear the accumulator; next state MAC.
- MAC, Order+1 cycles (tap k = 0..Order):
  - acc += history[ch][wr_ptr_latched - k mod (Order+1)] * coeff[k].
  - Multiplication is full precision, sign-extended to AccWidth.
- After the last tap: wr_ptr[ch] advances with wrap-around Order -> 0; next state OUT.
- Result formation:
  - Add 2^(CoeffFrac-1) to the accumulator, then arithmetic shift right by CoeffFrac (round half toward +inf).
  - Saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1].
  - Register the result into data_out_o.
- OUT:
  - data_out_req_o=1; data_out_o and data_out_ch_o held stable until data_out_gnt_i.
  - On grant, next state IDLE and data_out_req_o drops the following cycle.
  - data_in_gnt_o=0 and coeff_gnt_o=0 in MAC and OUT.
- Latency: sample granted at cycle t; data_out_req_o rises at cycle t+Order+2.
- Maximum throughput: one sample per Order+3 cycles when data_out_gnt_i is held high.
- clear_i:
  - Honoured only in IDLE; zeroes all histories and all write pointers in one cycle.
  - Coefficients are unchanged.
  - Ignored in MAC/OUT; the requester must hold it until IDLE.
- Simultaneous clear_i and data_in_req_i in IDLE: the clear wins and the input is not granted that cycle.
- Channel index >= NumChannels: sample is granted and dropped; no output is produced and no state changes.
- Coefficient write takes effect on the next computation.

Decomposition:
- Package fir_filter_pkg holds:
  - state_e enum (IDLE, MAC, OUT).
  - Function sat_round(acc) implementing rounding and saturation, parametrised through localparams.
- Natural sub-module: fir_mac. Registered multiply-accumulate with clear, enable, and the rounding/saturation output stage.
- Histories, pointers, coefficients and the FSM stay in fir_filter_mc.

Test Plan:
- Impulse: coeff[0]=0x4000, coeff[1]=0x2000, all others 0; ch0 inputs 1000, 0, 0 -> outputs 500, 250, 0, each with data_out_ch_o=0, each at t+17.
- Saturation: all 16 coeffs 0x7FFF; 16 inputs of 0x7FFF on ch2 -> final output 0x7FFF; repeat with 0x8000 inputs -> 0x8000.
- Rounding: coeff[0]=0x4000; input 3 -> 2; input -3 -> -1; input 1 -> 1.
- Channel isolation: impulse 1000 on ch1 interleaved with 0s on ch3 -> ch3 outputs all 0; ch1 response matches the impulse test.
- Backpressure and priority:
  - Hold data_out_gnt_i=0 for 5 cycles -> data_out_o stable and data_in_gnt_o=0 throughout.
  - coeff_we_i together with data_in_req_i in IDLE -> input granted first, coefficient write granted later.
- Reset/clear:
  - Assert rst_i in cycle 5 of MAC -> outputs 0 immediately; the next impulse gives a clean response.
  - clear_i in IDLE -> prior history is not visible in subsequent outputs.
